mac6x3_sequencer: RTL
=====================

// Module: mac6x3_sequencer
// PURPOSE
// - Pin-driven multiply-accumulate controller; time-shares one combinational 3x3 multiplier core.
// - Loads a 6-bit operand A and a 3-bit operand B over a 3-bit data bus.
// - Computes A*B in two multiplier passes (low half, then high half of A) and adds the result into a 12-bit accumulator.
// - Accumulator is read out 6 bits at a time; occupies one 8-in/8-out user slot.
// PARAMETERS
// - SYNC_STAGES  2   strobe synchroniser depth; legal values 2..3.
// - ACC_W        12  accumulator width; fixed by the two 6-bit readout halves.
// PORTS
// - io_in[0]    input   1  clk, single clock domain.
// - io_in[1]    input   1  reset, synchronous, active-high.
// - io_in[2]    input   1  strobe; asynchronous pin, command taken on synchronised rising edge.
// - io_in[4:3]  input   2  cmd: 00 LOAD_LO, 01 LOAD_HI, 10 LOAD_B_GO, 11 CTRL.
// - io_in[7:5]  input   3  data, sampled together with the strobe edge.
// - io_out[5:0] output  6  out_sel ? acc[11:6] : acc[5:0].
// - io_out[6]   output  1  ovf, sticky accumulator carry-out.
// - io_out[7]   output  1  busy, MAC sequence in progress.
// BEHAVIOUR
// - Reset: every register is cleared (acc, A, B, partial, ovf, out_sel, synchroniser, state=IDLE). All io_out bits are 0 in the cycle after reset is sampled high.
// - Reset mid-MAC: sequence aborts, no accumulator update.
// - Strobe path:
//   - strobe passes through SYNC_STAGES flops, then a rising-edge detect (prev flop).
//   - An edge in cycle N executes at clock edge N.
//   - cmd/data pass through the same synchroniser depth as strobe, so they are aligned with the edge.
// - Commands, executed only when state==IDLE:
//   - LOAD_LO: A[2:0] <= data.
//   - LOAD_HI: A[5:3] <= data.
//   - LOAD_B_GO: B <= data; state -> MUL_LO.
//   - CTRL: data[0]=1 clears acc and ovf; out_sel <= data[1]; data[2] is reserved and ignored.
// - Busy drop: an edge arriving while state!=IDLE is dropped completely, with no state change and no queueing.
// - FSM:
//   - IDLE -> MUL_LO on GO.
//   - MUL_LO: mul inputs = (A[2:0], B); partial <= product (6b); -> MUL_HI.
//   - MUL_HI: mul inputs = (A[5:3], B); acc <= acc + partial + (product<<3) mod 2^12; -> IDLE.
//   - In MUL_HI, ovf <= ovf | carry out of bit 11.
// - busy = (state!=IDLE). It is high for exactly 2 cycles per GO; the accumulator is valid on the cycle busy falls.
// - Arithmetic: all unsigned. The per-MAC sum is at most 63*7=441. The accumulator wraps modulo 4096; ovf stays set until CTRL clear or reset.
// - Operand retention: A and B keep their values after a MAC, so repeated GO with the same data re-accumulates.
// - Outputs: io_out[5:0] is a combinational mux of registered acc/out_sel; io_out[7:6] are registered-derived. No glitch requirement.
// STRUCTURE
// - Package mac6x3_pkg:
//   - cmd encodings CMD_LOAD_LO/CMD_LOAD_HI/CMD_LOAD_B_GO/CMD_CTRL.
//   - state enum {IDLE, MUL_LO, MUL_HI}.
//   - ACC_W and CTRL bit indices.
// - One sub-module: mul3x3_core, the 3x3->6 unsigned combinational multiplier.
//   - Single instance, inputs muxed by state; out-of-MAC inputs are don't-care.
// - Sequencer, synchroniser, edge detect and accumulator live in the top.
// TESTING
// - Reset: hold reset 2 cycles with strobe toggling -> io_out==8'h00, no command executed.
// - Basic MAC: LOAD_LO 5, LOAD_HI 5 (A=45), LOAD_B_GO 6 -> busy high 2 cycles, then acc=270; io_out[5:0]=14; CTRL data=010 -> io_out[5:0]=4.
// - Wrap: A=63, B=7, GO ten times -> acc=314 (4410-4096), io_out[6]=1; CTRL data=001 -> acc=0, ovf=0.
// - Busy drop: GO, then LOAD_LO edge landing in MUL_HI -> A unchanged, single 441 accumulated.
// - Abort: reset asserted in MUL_LO -> busy=0, acc=0 next cycle; a later MAC runs normally.
// - Sync latency: strobe rise -> command effect exactly SYNC_STAGES+1 clocks later; check for SYNC_STAGES=2 and 3.

Source files
------------

// File: rtl/mac6x3_pkg.sv
// Shared encodings for the 6x3 multiply-accumulate sequencer.
package mac6x3_pkg;

  localparam int ACC_W        = 12;
  localparam int CTRL_CLR_BIT = 0;
  localparam int CTRL_SEL_BIT = 1;

  typedef enum logic [1:0] {
    CMD_LOAD_LO   = 2'b00,
    CMD_LOAD_HI   = 2'b01,
    CMD_LOAD_B_GO = 2'b10,
    CMD_CTRL      = 2'b11
  } cmd_e;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    MUL_LO = 2'd1,
    MUL_HI = 2'd2
  } state_e;

endpackage

// File: rtl/mul3x3_core.sv
// Unsigned 3x3 -> 6 bit combinational multiplier, time-shared by the sequencer.
module mul3x3_core (
  input  logic [2:0] a,
  input  logic [2:0] b,
  output logic [5:0] p
);

  // Operands widened to the product width so no bits are lost.
  always_comb begin
    p = {3'b000, a} * {3'b000, b};
  end

endmodule

// File: rtl/mac6x3_sequencer.sv
// Pin-driven MAC controller: loads A (6b) and B (3b) over a 3-bit bus, computes
// A*B in two passes of a shared 3x3 multiplier and accumulates into 12 bits.
module mac6x3_sequencer #(
  parameter int SYNC_STAGES = 2,
  parameter int ACC_W       = mac6x3_pkg::ACC_W
) (
  input  logic [7:0] io_in,
  output logic [7:0] io_out
);

  import mac6x3_pkg::*;

  if (SYNC_STAGES < 2 || SYNC_STAGES > 3) begin : g_bad_sync
    $error("SYNC_STAGES must be 2 or 3");
  end

  logic clk;
  logic rst;
  logic [5:0] pin_bus;

  assign clk     = io_in[0];
  assign rst     = io_in[1];
  assign pin_bus = io_in[7:2];  // {data, cmd, strobe}

  logic [SYNC_STAGES-1:0][5:0] sync_q, sync_d;
  logic                        strb_prev_q, strb_prev_d;
  state_e                      state_q, state_d;
  logic [5:0]                  a_q, a_d;
  logic [2:0]                  b_q, b_d;
  logic [5:0]                  partial_q, partial_d;
  logic [ACC_W-1:0]            acc_q, acc_d;
  logic                        ovf_q, ovf_d;
  logic                        out_sel_q, out_sel_d;

  logic [5:0]                  sync_out;
  logic                        cmd_edge;
  cmd_e                        cmd;
  logic [2:0]                  cmd_data;
  logic [2:0]                  mul_a;
  logic [5:0]                  mul_p;
  logic [ACC_W:0]              mac_sum;

  assign sync_out = sync_q[SYNC_STAGES-1];
  assign cmd_edge = sync_out[0] & ~strb_prev_q;
  assign cmd      = cmd_e'(sync_out[2:1]);
  assign cmd_data = sync_out[5:3];

  mul3x3_core u_mul (
    .a (mul_a),
    .b (b_q),
    .p (mul_p)
  );

  // Strobe, cmd and data shift together so the command is aligned with the edge.
  always_comb begin
    sync_d      = {sync_q[SYNC_STAGES-2:0], pin_bus};
    strb_prev_d = sync_out[0];
  end

  // Command decode, two-pass multiply sequencing and accumulation.
  always_comb begin
    state_d   = state_q;
    a_d       = a_q;
    b_d       = b_q;
    partial_d = partial_q;
    acc_d     = acc_q;
    ovf_d     = ovf_q;
    out_sel_d = out_sel_q;
    mul_a     = a_q[2:0];
    mac_sum   = {1'b0, acc_q} + (ACC_W+1)'(partial_q) + (ACC_W+1)'({mul_p, 3'b000});

    case (state_q)
      IDLE: begin
        if (cmd_edge) begin
          case (cmd)
            CMD_LOAD_LO: a_d[2:0] = cmd_data;
            CMD_LOAD_HI: a_d[5:3] = cmd_data;
            CMD_LOAD_B_GO: begin
              b_d     = cmd_data;
              state_d = MUL_LO;
            end
            CMD_CTRL: begin
              if (cmd_data[CTRL_CLR_BIT]) begin
                acc_d = '0;
                ovf_d = 1'b0;
              end
              out_sel_d = cmd_data[CTRL_SEL_BIT];
            end
          endcase
        end
      end
      MUL_LO: begin
        mul_a     = a_q[2:0];
        partial_d = mul_p;
        state_d   = MUL_HI;
      end
      MUL_HI: begin
        mul_a   = a_q[5:3];
        acc_d   = mac_sum[ACC_W-1:0];
        ovf_d   = ovf_q | mac_sum[ACC_W];
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // All state registers, synchronous active-high reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q      <= '0;
      strb_prev_q <= 1'b0;
      state_q     <= IDLE;
      a_q         <= '0;
      b_q         <= '0;
      partial_q   <= '0;
      acc_q       <= '0;
      ovf_q       <= 1'b0;
      out_sel_q   <= 1'b0;
    end else begin
      sync_q      <= sync_d;
      strb_prev_q <= strb_prev_d;
      state_q     <= state_d;
      a_q         <= a_d;
      b_q         <= b_d;
      partial_q   <= partial_d;
      acc_q       <= acc_d;
      ovf_q       <= ovf_d;
      out_sel_q   <= out_sel_d;
    end
  end

  assign io_out = {state_q != IDLE, ovf_q,
                   out_sel_q ? acc_q[ACC_W-1:ACC_W/2] : acc_q[ACC_W/2-1:0]};

endmodule
